// File: rtl/cim_pkg.sv
// Shared constants and state encoding for the CIM array programming path.
package cim_pkg;

    localparam int NUM_ROWS       = 64;
    localparam int WBL_W          = 64;
    localparam int NUM_BL         = 16;
    localparam int WR_CYCLES_DEF  = 4;
    localparam int PRE_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CAP   = 3'd1,
        S_REQ   = 3'd2,
        S_PULSE = 3'd3,
        S_PRE   = 3'd4,
        S_DONE  = 3'd5
    } wrow_state_t;

endpackage

// File: rtl/cim_phase_timer.sv
// Loadable down-counter with a zero flag; times both the write pulse and the
// precharge phase. Load with (length - 1); o_zero marks the final cycle.
module cim_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/wbl_row_writer.sv
// Row-by-row programming sequencer: captures each key-derived WBL row from
// wbl_key_gen and writes it into the CIM array with timed pulse/precharge.
// Every output is a register; phase flags are decoded from the next state so
// they line up with the state they describe.
module wbl_row_writer
    import cim_pkg::*;
#(
    parameter int NUM_ROWS   = cim_pkg::NUM_ROWS,
    parameter int WBL_W      = cim_pkg::WBL_W,
    parameter int NUM_BL     = cim_pkg::NUM_BL,
    parameter int WR_CYCLES  = cim_pkg::WR_CYCLES_DEF,
    parameter int PRE_CYCLES = cim_pkg::PRE_CYCLES_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [127:0]                    key_in,
    output logic [127:0]                    kin,
    output logic [$clog2(NUM_ROWS)-1:0]     addr,
    input  logic [NUM_BL*WBL_W-1:0]         wbl_in,
    output logic                            wr_req,
    input  logic                            wr_ack,
    output logic [$clog2(NUM_ROWS)-1:0]     wl_addr,
    output logic [NUM_BL*WBL_W-1:0]         wbl_data,
    output logic                            wl_en,
    output logic                            pre_en,
    output logic                            busy,
    output logic                            done,
    output logic                            aborted
);

    localparam int AW   = $clog2(NUM_ROWS);
    localparam int DW   = NUM_BL * WBL_W;
    localparam int TMAX = (WR_CYCLES > PRE_CYCLES) ? WR_CYCLES : PRE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    wrow_state_t   r_state;
    wrow_state_t   w_nxt;
    logic          r_abort;
    logic [127:0]  r_kin;
    logic [AW-1:0] r_row;
    logic [AW-1:0] r_wl_addr;
    logic [DW-1:0] r_wbl_data;
    logic          r_wr_req;
    logic          r_wl_en;
    logic          r_pre_en;
    logic          r_busy;
    logic          r_done;
    logic          r_aborted;

    logic          w_abort_eff;
    logic          w_row_inc;
    logic          w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic          w_tmr_zero;

    cim_phase_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tmr_load),
        .i_val  (w_tmr_val),
        .o_zero (w_tmr_zero)
    );

    // An abort seen this cycle counts immediately so a last-cycle abort in PRE
    // still ends the pass; abort in IDLE never arms the flag.
    assign w_abort_eff = r_abort | (abort && (r_state != S_IDLE));

    // Next-state decode, phase timer loads and row advance.
    always_comb begin
        w_nxt      = r_state;
        w_row_inc  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            S_IDLE:  if (start) w_nxt = S_CAP;
            S_CAP:   w_nxt = S_REQ;
            S_REQ: begin
                if (wr_ack) begin
                    w_nxt      = S_PULSE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(WR_CYCLES - 1);
                end
            end
            S_PULSE: begin
                if (w_tmr_zero) begin
                    w_nxt      = S_PRE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(PRE_CYCLES - 1);
                end
            end
            S_PRE: begin
                if (w_tmr_zero) begin
                    if (w_abort_eff || (r_row == AW'(NUM_ROWS - 1))) begin
                        w_nxt = S_DONE;
                    end else begin
                        w_nxt     = S_CAP;
                        w_row_inc = 1'b1;
                    end
                end
            end
            S_DONE:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // State, sticky abort flag and registered phase outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_abort   <= 1'b0;
            r_wr_req  <= 1'b0;
            r_wl_en   <= 1'b0;
            r_pre_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_abort   <= (r_state == S_DONE) ? 1'b0 : w_abort_eff;
            r_wr_req  <= (w_nxt == S_REQ);
            r_wl_en   <= (w_nxt == S_PULSE);
            r_pre_en  <= (w_nxt == S_PRE);
            r_busy    <= (w_nxt == S_CAP) || (w_nxt == S_REQ) ||
                         (w_nxt == S_PULSE) || (w_nxt == S_PRE);
            r_done    <= (w_nxt == S_DONE);
            r_aborted <= (w_nxt == S_DONE) && w_abort_eff;
        end
    end

    // Key latch and row counter; the counter never wraps and holds after a pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kin <= '0;
            r_row <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_kin <= key_in;
            r_row <= '0;
        end else if (w_row_inc) begin
            r_row <= r_row + 1'b1;
        end
    end

    // Row capture at the end of CAP; held until the next CAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wl_addr  <= '0;
            r_wbl_data <= '0;
        end else if (r_state == S_CAP) begin
            r_wl_addr  <= r_row;
            r_wbl_data <= wbl_in;
        end
    end

    assign kin      = r_kin;
    assign addr     = r_row;
    assign wl_addr  = r_wl_addr;
    assign wbl_data = r_wbl_data;
    assign wr_req   = r_wr_req;
    assign wl_en    = r_wl_en;
    assign pre_en   = r_pre_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign aborted  = r_aborted;

endmodule

// File: tb/tb_wbl_row_writer.sv
// Scoreboard bench for wbl_row_writer with a behavioural key-generator stand-in.
module tb_wbl_row_writer;

    localparam int DW = 1024;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [127:0]   key_in;
    logic [127:0]   kin;
    logic [5:0]     addr;
    logic [DW-1:0]  wbl_in;
    logic           wr_req;
    logic           wr_ack = 1'b1;
    logic [5:0]     wl_addr;
    logic [DW-1:0]  wbl_data;
    logic           wl_en;
    logic           pre_en;
    logic           busy;
    logic           done;
    logic           aborted;

    always #5 clk = ~clk;

    wbl_row_writer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .key_in   (key_in),
        .kin      (kin),
        .addr     (addr),
        .wbl_in   (wbl_in),
        .wr_req   (wr_req),
        .wr_ack   (wr_ack),
        .wl_addr  (wl_addr),
        .wbl_data (wbl_data),
        .wl_en    (wl_en),
        .pre_en   (pre_en),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    // Golden row generator standing in for wbl_key_gen.
    function automatic logic [DW-1:0] gen_row(input logic [127:0] k, input logic [5:0] a);
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++)
            r[i*64 +: 64] = ({58'b0, a} * 64'h9E3779B97F4A7C15) ^ (64'(i) << 48) ^
                            k[63:0] ^ k[127:64] ^ 64'h0123_4567_89AB_CDEF ^ 64'(a);
        return r;
    endfunction

    assign wbl_in = gen_row(kin, addr);

    typedef struct { logic [5:0] a; logic [DW-1:0] d; int len; } xfer_t;
    typedef struct { int cyc; logic ab; } done_t;
    xfer_t xq[$];
    done_t dq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int bp_row = -1;
    int bp_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Array-side acknowledge: withhold ack for bp_left REQ cycles on bp_row.
    always @(posedge clk) begin
        #1;
        if (wr_req && (int'(wl_addr) == bp_row) && (bp_left > 0)) begin
            wr_ack = 1'b0;
            bp_left--;
        end else begin
            wr_ack = 1'b1;
        end
    end

    // Monitor: checks transfers, phase lengths and done pulses against queues.
    int req_run = 0, wl_run = 0, pre_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            req_run = 0; wl_run = 0; pre_run = 0;
        end else begin
            if (wr_req) begin
                req_run++;
                if (xq.size() == 0) begin
                    chk("unexpected_req_addr", 64'(wl_addr), 64'hFFFF);
                end else begin
                    chk("req_wl_addr", 64'(wl_addr), 64'(xq[0].a));
                    tests++;
                    if (wbl_data !== xq[0].d) begin
                        fails++;
                        $display("FAIL req_wbl_data row %0d: got low %h expected low %h",
                                 xq[0].a, wbl_data[63:0], xq[0].d[63:0]);
                    end
                    if (wr_ack) begin
                        chk("req_cycles", 64'(req_run), 64'(xq[0].len));
                        void'(xq.pop_front());
                    end
                end
                if (wr_ack) req_run = 0;
            end
            if (wl_en) wl_run++;
            else if (wl_run != 0) begin chk("pulse_len", 64'(wl_run), 64'd4); wl_run = 0; end
            if (pre_en) pre_run++;
            else if (pre_run != 0) begin chk("pre_len", 64'(pre_run), 64'd2); pre_run = 0; end
            if (done) begin
                done_cnt++;
                chk("busy_in_done", 64'(busy), 64'd0);
                if (dq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    chk("done_cycle", 64'(cyc), 64'(dq[0].cyc));
                    chk("aborted_flag", 64'(aborted), 64'(dq[0].ab));
                    void'(dq.pop_front());
                end
            end
        end
    end

    task automatic issue_pass(input logic [127:0] k, input logic with_abort, input int nrows,
                              input int bp_r, input int bp_n, input logic exp_ab);
        for (int r = 0; r < nrows; r++)
            xq.push_back('{a: 6'(r), d: gen_row(k, 6'(r)), len: (r == bp_r) ? bp_n + 1 : 1});
        bp_row = bp_r;
        bp_left = bp_n;
        @(negedge clk);
        key_in = k; start = 1'b1; abort = with_abort;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        dq.push_back('{cyc: cyc + nrows * 8 + bp_n, ab: exp_ab});
    endtask

    task automatic wait_done(input string nm);
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while ((done_cnt == c0) && (n < 800)) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(done_cnt != c0), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pulse_row(input int row);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(wl_en && (int'(wl_addr) == row)) && (n < 300));
        chk("pulse_row_seen", 64'(wl_en && (int'(wl_addr) == row)), 64'd1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_kin_lo"}, kin[63:0], 64'd0);
        chk({nm, "_kin_hi"}, kin[127:64], 64'd0);
        chk({nm, "_addr"}, 64'(addr), 64'd0);
        chk({nm, "_wl_addr"}, 64'(wl_addr), 64'd0);
        chk({nm, "_wbl_data_nz"}, 64'(|wbl_data), 64'd0);
        chk({nm, "_flags"}, 64'({wr_req, wl_en, pre_en, busy, done, aborted}), 64'd0);
    endtask

    localparam logic [127:0] K1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] K2 = 128'hDEADBEEF00C0FFEE_1234567811223344;
    localparam logic [127:0] K3 = 128'hA5A5A5A55A5A5A5A_0F0F0F0FF0F0F0F0;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; key_in = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full pass, zero key.
        issue_pass(128'd0, 1'b0, 64, -1, 0, 1'b0);
        wait_done("passA_done_seen");
        chk("passA_addr_hold", 64'(addr), 64'd63);
        chk("passA_idle_busy", 64'(busy), 64'd0);

        // Back-pressure on row 10.
        issue_pass(K1, 1'b0, 64, 10, 5, 1'b0);
        wait_done("passB_done_seen");
        chk("passB_kin_lo", kin[63:0], K1[63:0]);

        // Abort during the pulse of row 3.
        issue_pass(K2, 1'b0, 4, -1, 0, 1'b1);
        wait_pulse_row(3);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        chk("abort_wl_en_held", 64'(wl_en), 64'd1);
        wait_done("passC_done_seen");
        chk("passC_addr_hold", 64'(addr), 64'd3);

        // Reset in the second pulse cycle of row 7.
        issue_pass(K1, 1'b0, 64, -1, 0, 1'b0);
        wait_pulse_row(7);
        @(posedge clk); #2;
        chk("pre_reset_wl_en", 64'(wl_en), 64'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        xq.delete();
        dq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Start with abort in IDLE, then ignored start and key change mid-pass.
        issue_pass(K3, 1'b1, 64, -1, 0, 1'b0);
        repeat (50) @(negedge clk);
        start = 1'b1; key_in = K1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ignored_kin_lo", kin[63:0], K3[63:0]);
        chk("ignored_kin_hi", kin[127:64], K3[127:64]);
        wait_done("passE_done_seen");
        chk("passE_kin_hold", kin[127:64], K3[127:64]);

        chk("xfer_queue_empty", 64'(xq.size()), 64'd0);
        chk("done_queue_empty", 64'(dq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wbl_row_writer.md
# wbl_row_writer

Sequencer between `wbl_key_gen` and the DRAM CIM array write port. On `start` it latches a 128-bit AES key, drives it and a row address to `wbl_key_gen`, and captures the 16×64-bit WBL word for each of the 64 rows. It then hands each captured row to the array through a request/acknowledge handshake and times the write-pulse and precharge phases. It replaces boot-time ROM preloading with a key-driven array programming pass.

## Interface

Parameters:
- `NUM_ROWS`, 64: rows programmed per pass. The address width is log2 of this value, 6.
- `WBL_W`, 64: width of one WBL word.
- `NUM_BL`, 16: number of WBL words per row.
- `WR_CYCLES`, 4: write-pulse length in cycles. Minimum 1.
- `PRE_CYCLES`, 2: precharge length in cycles. Minimum 1.

Ports:
- `clk`  in  1  sole clock. All state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a programming pass. Sampled only in IDLE.
- `abort`  in  1  stops the pass at the next row boundary.
- `key_in`  in  128  AES key. Latched on the accepted `start`.
- `kin`  out  128  latched key, driven to `wbl_key_gen.Kin`.
- `addr`  out  6  row index, driven to `wbl_key_gen.addr`.
- `wbl_in`  in  1024  `{WBL16,…,WBL1}`. WBL1 occupies bits [63:0].
- `wr_req`  out  1  row write request to the array.
- `wr_ack`  in  1  array accepts the request.
- `wl_addr`  out  6  word-line address of the row being written.
- `wbl_data`  out  1024  captured WBL word, held stable from CAP through PRE.
- `wl_en`  out  1  write pulse (word line enable).
- `pre_en`  out  1  precharge phase indicator.
- `busy`  out  1  high in CAP, REQ, PULSE and PRE.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `aborted`  out  1  one-cycle pulse, coincident with `done`, when the pass was cut short.

## Operation

States are IDLE, CAP, REQ, PULSE, PRE and DONE.

- **IDLE**
  - `start`=1 latches `key_in` into `kin` and sets the row counter to 0.
  - Next state is CAP.
- **CAP**
  - `addr` is the row counter. `wbl_key_gen` is combinational and settles within the cycle.
  - At the end of the cycle, `wbl_in` is registered into `wbl_data` and the row counter into `wl_addr`.
  - Next state is REQ.
- **REQ**
  - `wr_req`=1.
  - If `wr_ack`=1 in the same cycle, the transfer completes and the next state is PULSE. Otherwise the FSM holds in REQ with `wr_req`, `wl_addr` and `wbl_data` unchanged.
  - `wr_ack` outside REQ is ignored.
- **PULSE**
  - `wl_en`=1 for exactly `WR_CYCLES` cycles, counted by a down-counter.
  - Next state is PRE.
- **PRE**
  - `pre_en`=1 for exactly `PRE_CYCLES` cycles.
  - In the last cycle:
    - If the abort flag is set, or the row counter is `NUM_ROWS-1`, the next state is DONE.
    - Otherwise the row counter increments and the next state is CAP.
- **DONE**
  - `done`=1 for one cycle, `busy`=0.
  - `aborted`=1 if the abort flag was set. The abort flag clears.
  - Next state is IDLE.

Rules:
- `abort` sampled high in any state other than IDLE sets a sticky abort flag.
- A PULSE or PRE phase already in progress is never truncated. An abort raised in CAP or REQ still completes that row.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: `start` wins and `abort` is ignored.
- `key_in` changes after acceptance have no effect until the next pass.
- The row counter does not wrap. `addr` holds its last value (63 on a full pass) in DONE and IDLE.
- `kin` holds its value until the next accepted `start`.

## Timing

- All outputs are registered.
- Reset values: `kin`=0, `addr`=0, `wl_addr`=0, `wbl_data`=0; `wr_req`, `wl_en`, `pre_en`, `busy`, `done` and `aborted` all 0. State after reset is IDLE and the abort flag is clear.
- `rst` asserted mid-pass forces all of the above immediately, including dropping `wl_en` in the middle of a pulse. There is no resumption.
- Per-row cost is 1 (CAP) + (1 + ack wait) (REQ) + `WR_CYCLES` + `PRE_CYCLES`. With `wr_ack` tied high and default parameters this is 8 cycles.
- Full pass with defaults:
  - `start` is sampled at edge E0.
  - `busy` is high from cycle 1 through cycle 512.
  - `done` is high in cycle 513.
- `wbl_data` and `wl_addr` are stable from the cycle after CAP until the next CAP.

## Structure

- Shared package `cim_pkg` holds `NUM_ROWS`, `WBL_W`, `NUM_BL`, the state enum `wrow_state_t`, and the default `WR_CYCLES` and `PRE_CYCLES`.
- `wbl_key_gen` is instantiated by the parent, not inside this block.
- One sub-module is natural: `cim_phase_timer`, a loadable down-counter with a `zero` flag, shared by PULSE and PRE.

## Test plan

- **Full pass, zero key.** `key_in`=0, `wr_ack`=1, `start` pulsed, real `wbl_key_gen` connected.
  - Exactly 64 REQ transfers with `wl_addr` 0..63 in order.
  - Each captured `wbl_data` equals the golden ROM row for that address.
  - `done` in cycle 513; `aborted`=0.
- **Back-pressure.** `wr_ack` low for 5 cycles on row 10.
  - REQ holds 6 cycles with `wl_addr`=10 and `wbl_data` unchanged.
  - The pass completes 5 cycles late.
- **Abort mid-pulse.** `abort` pulsed during the PULSE of row 3.
  - `wl_en` stays high for all 4 cycles and PRE completes.
  - `done`=`aborted`=1 with no row 4 request.
- **Reset mid-pulse.** `rst` asserted in the second PULSE cycle of row 7.
  - All outputs go to 0 asynchronously; state is IDLE.
  - A subsequent `start` restarts at row 0.
- **Ignored inputs.** `start` re-pulsed while `busy`, and `key_in` changed mid-pass.
  - `kin` unchanged and the pass is unaffected.
- **Start/abort collision.** `start` and `abort` asserted together in IDLE.
  - The pass starts and runs all 64 rows.
